multi_slave_bridge: RTL and testbench

MULTI_SLAVE_BRIDGE -- requirements
Module: multi_slave_bridge

---
 rtl/multi_slave_bridge_if.sv | 33 +++
 rtl/multi_slave_bridge.sv | 128 ++++++++++++
 tb/tb_multi_slave_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multi_slave_bridge_if.sv
// Bus bundle between an initiator, the multi_slave_bridge and its slave ports.
// The slave modport is the bridge's view; the master modport is the initiator/slave-side stimulus view.
interface multi_slave_bridge_if #(
  parameter int unsigned NUM_SLAVES = 4
);
  logic                      req;
  logic                      writeEnable;
  logic [31:0]               address;
  logic [31:0]               writeDataIn;
  logic                      busy;
  logic                      respValid;
  logic [31:0]               readData;
  logic                      exception;
  logic [1:0]                errCode;
  logic [NUM_SLAVES-1:0]     sel;
  logic [NUM_SLAVES-1:0]     slvWE;
  logic [3:0]                slvAddr;
  logic [31:0]               slvWData;
  logic [32*NUM_SLAVES-1:0]  slvRData;
  logic [NUM_SLAVES-1:0]     slvReady;

  modport slave (
    input  req, writeEnable, address, writeDataIn, slvRData, slvReady,
    output busy, respValid, readData, exception, errCode,
           sel, slvWE, slvAddr, slvWData
  );

  modport master (
    output req, writeEnable, address, writeDataIn, slvRData, slvReady,
    input  busy, respValid, readData, exception, errCode,
           sel, slvWE, slvAddr, slvWData
  );
endinterface

// File: rtl/multi_slave_bridge.sv
// Single-initiator to N-slave address-decoding bridge with alignment check,
// per-access ready timeout and a one-cycle completion pulse.
module multi_slave_bridge #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h7F00,
  parameter logic [15:0] STRIDE     = 16'h0010,
  parameter int unsigned WR_WORDS   = 2,
  parameter int unsigned RD_WORDS   = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic              clk,
  input logic              reset,
  multi_slave_bridge_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0]  TMO   = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  wr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [3:0]            woff_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [7:0]            cnt_q;
  logic [1:0]            err_q;

  logic                  misaligned;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [3:0]            dec_woff;
  logic [15:0]           dec_off;
  logic [15:0]           dec_lim;
  logic                  ready_sel;
  logic [NUM_SLAVES-1:0] sel_vec;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.address[31:16];
  assign misaligned     = |bus.address[1:0];

  // Offsets below a window base wrap to large values and fail the limit test.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_woff = '0;
    dec_off  = '0;
    dec_lim  = bus.writeEnable ? 16'(WR_WORDS * 4) : 16'(RD_WORDS * 4);
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      dec_off = bus.address[15:0] - (BASE_ADDR + 16'(i) * STRIDE);
      if (!dec_hit && (dec_off < dec_lim)) begin
        dec_hit  = 1'b1;
        dec_idx  = IDX_W'(i);
        dec_woff = dec_off[5:2];
      end
    end
  end

  assign ready_sel = bus.slvReady[idx_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.req) state_next = (misaligned || !dec_hit) ? RESP : ACCESS;
      ACCESS:  if (ready_sel || (cnt_q == TMO)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      woff_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.req) begin
          wr_q    <= bus.writeEnable;
          wdata_q <= bus.writeDataIn;
          rdata_q <= '0;
          cnt_q   <= '0;
          idx_q   <= dec_idx;
          woff_q  <= dec_woff;
          err_q   <= misaligned ? 2'd2 : (dec_hit ? 2'd0 : 2'd1);
        end
        // Ready on the final counted cycle still wins over the timeout.
        ACCESS: begin
          if (ready_sel) begin
            err_q <= 2'd0;
            if (!wr_q) rdata_q <= bus.slvRData[32*idx_q +: 32];
          end else if (cnt_q == TMO) begin
            err_q <= 2'd3;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel_vec       = (state == ACCESS) ? (NUM_SLAVES'(1) << idx_q) : '0;
  assign bus.sel       = sel_vec;
  assign bus.slvWE     = sel_vec & {NUM_SLAVES{wr_q}};
  assign bus.slvAddr   = woff_q;
  assign bus.slvWData  = wdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.respValid = (state == RESP);
  assign bus.errCode   = (state == RESP) ? err_q : '0;
  assign bus.exception = (state == RESP) && (err_q != 2'd0);
  assign bus.readData  = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_multi_slave_bridge.sv
// Randomized self-checking bench for multi_slave_bridge against an
// arithmetic address-map and latency model.
module tb_multi_slave_bridge;

  localparam int NS   = 4;
  localparam int BASE = 'h7F00;
  localparam int STR  = 'h10;
  localparam int WRW  = 2;
  localparam int RDW  = 3;
  localparam int TMO  = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multi_slave_bridge_if #(.NUM_SLAVES(NS)) bus ();

  multi_slave_bridge #(
    .NUM_SLAVES(NS),
    .BASE_ADDR (16'h7F00),
    .STRIDE    (16'h0010),
    .WR_WORDS  (WRW),
    .RD_WORDS  (RDW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address map: windows of STR bytes starting at BASE, RDW/WRW words usable.
  function automatic void model(input logic we, input logic [31:0] a,
                                output int err, output int idx, output int woff);
    int rel, lim;
    err = 0; idx = 0; woff = 0;
    lim = (we ? WRW : RDW) * 4;
    rel = int'(a[15:0]) - BASE;
    if (a[1:0] != 2'b00)                                   err = 2;
    else if (rel < 0 || rel / STR >= NS || rel % STR >= lim) err = 1;
    else begin
      idx  = rel / STR;
      woff = (rel % STR) / 4;
    end
  endfunction

  // d: wait cycle in which the selected slave raises ready (d > TMO: never).
  task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input bit pulse);
    int err, idx, woff, acc, last, pulse_at, exp_err;
    logic [31:0]   rd [NS];
    logic [NS-1:0] exp_sel;
    logic [31:0]   exp_rd;
    logic          b_exp, v_exp;
    model(we, a, err, idx, woff);
    acc      = (err != 0) ? 0 : ((d < TMO ? d : TMO) + 1);
    last     = acc + 1;
    pulse_at = pulse ? $urandom_range(1, last) : 0;
    exp_err  = (err != 0) ? err : ((d <= TMO) ? 0 : 3);
    exp_rd   = '0;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      rd[i] = $urandom;
      bus.slvRData[32*i +: 32] = rd[i];
    end
    if (exp_err == 0 && !we) exp_rd = rd[idx];
    bus.req = 1'b1; bus.writeEnable = we; bus.address = a; bus.writeDataIn = wd;
    bus.slvReady = '0;
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      bus.req = (n == pulse_at);
      if (n == pulse_at) begin
        bus.address = $urandom; bus.writeEnable = 1'($urandom); bus.writeDataIn = $urandom;
      end
      exp_sel = (n <= acc) ? (NS'(1) << idx) : '0;
      b_exp   = (n <= last);
      v_exp   = (n == last);
      check("busy_resp_sel", {bus.busy, bus.respValid, bus.sel}, {b_exp, v_exp, exp_sel});
      if (n == 1 && acc > 0) begin
        check("slvWE",    bus.slvWE,    we ? exp_sel : '0);
        check("slvAddr",  bus.slvAddr,  woff);
        check("slvWData", bus.slvWData, wd);
      end
      if (n == last) begin
        check("errCode",   bus.errCode,   exp_err);
        check("exception", bus.exception, exp_err != 0);
        check("readData",  bus.readData,  exp_rd);
      end
      bus.slvReady = NS'($urandom);
      if (n <= acc) bus.slvReady[idx] = (n - 1 == d);
    end
    bus.req = 1'b0;
    bus.slvReady = '0;
  endtask

  initial begin
    logic [31:0] a;
    int d;
    bus.req = 1'b0; bus.writeEnable = 1'b0; bus.address = '0; bus.writeDataIn = '0;
    bus.slvRData = '0; bus.slvReady = '0;
    #1;
    check("rst_outputs", {bus.busy, bus.respValid, bus.exception, bus.errCode, bus.sel, bus.slvWE},
          '0);
    check("rst_data", {bus.readData, bus.slvWData}, '0);
    check("rst_slvAddr", bus.slvAddr, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_txn(1'b1, 32'h0000_7F14, 32'hDEAD_BEEF, 0, 1'b0);
    do_txn(1'b0, 32'h0000_7F08, 32'h0, 0, 1'b0);
    do_txn(1'b1, 32'h0000_7F08, 32'h1, 0, 1'b0);
    do_txn(1'b0, 32'h0000_7F02, 32'h2, 0, 1'b0);
    do_txn(1'b0, 32'h0000_7F40, 32'h3, 0, 1'b0);
    do_txn(1'b0, 32'h0000_7F30, 32'h4, TMO + 5, 1'b0);
    do_txn(1'b0, 32'h0000_7F30, 32'h5, TMO - 1, 1'b0);
    do_txn(1'b0, 32'h0000_7F30, 32'h6, TMO, 1'b0);
    do_txn(1'b1, 32'h0000_7EFC, 32'h7, 0, 1'b0);
    do_txn(1'b0, 32'h0000_7F10, 32'h8, 3, 1'b1);

    // Reset in the third ACCESS cycle must drop sel at once, with no response.
    @(negedge clk);
    bus.req = 1'b1; bus.writeEnable = 1'b1; bus.address = 32'h7F30; bus.writeDataIn = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_sel", bus.sel, 4'b1000);
    reset = 1'b0;
    #1;
    check("async_rst", {bus.busy, bus.respValid, bus.sel, bus.slvWE}, '0);
    check("async_rst_wdata", bus.slvWData, '0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_resp", bus.respValid, 1'b0);
    end
    reset = 1'b1;
    do_txn(1'b0, 32'h0000_7F30, 32'h9, 2, 1'b0);

    for (int t = 0; t < 150; t++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        a[15:0] = 16'(BASE + $urandom_range(0, NS * STR + STR - 1));
        if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      end
      case ($urandom_range(0, 4))
        0:       d = 0;
        1:       d = TMO;
        2:       d = TMO + 1;
        default: d = $urandom_range(0, TMO);
      endcase
      do_txn(1'($urandom), a, $urandom, d, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
